spi_flash_ctrl: RTL and testbench

Read-only SPI NOR flash controller that sequences Fast Read transactions on the user-area flash pins (mprj_io[8..13]) on behalf of a single word-fetch requester (Microwatt boot/instruction path). Accepts one 24-bit byte address, runs command/address/dummy/data phases in SPI mode 0 and returns one 32-bit little-endian word. Sits between the CPU's flash-read port and the GPIO pad wrappers.

---
 rtl/spi_flash_pkg.sv | 33 +++
 rtl/spi_flash_sck_gen.sv | 29 ++
 rtl/spi_flash_ctrl.sv | 107 ++++++++++
 tb/tb_spi_flash_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: shared state, opcodes and phase lengths for the SPI flash controller.
// SPI_FLASH_QUAD_EN selects Quad Output Fast Read (0x6B) instead of single Fast Read (0x0B).
package spi_flash_pkg;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, DESEL} state_e;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam logic [7:0] CMD_QUAD_READ = 8'h6B;
  localparam int CMD_BITS = 8;
  localparam int ADDR_BITS = 24;
  localparam int DATA_BITS = 32;
  localparam logic [3:0] OE_SINGLE = 4'b1101;
`ifdef SPI_FLASH_QUAD_EN
  localparam logic [7:0] CMD_OP = CMD_QUAD_READ;
  localparam int DATA_CYCLES = DATA_BITS / 4;
  localparam logic [3:0] OE_DATA = 4'b0000;
`else
  localparam logic [7:0] CMD_OP = CMD_FAST_READ;
  localparam int DATA_CYCLES = DATA_BITS;
  localparam logic [3:0] OE_DATA = OE_SINGLE;
`endif

  // Quad shifts a whole nibble (io3 = MSB); single takes only io1 (flash SO).
  function automatic logic [31:0] shift_in(input logic [31:0] sh, input logic [3:0] io);
`ifdef SPI_FLASH_QUAD_EN
    return 32'({sh, io});
`else
    return 32'({sh, ^(io & 4'b0010)});
`endif
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
endpackage

// File: rtl/spi_flash_sck_gen.sv
// spi_flash_sck_gen: SCK divider; idles low while disabled, strobes mark the clk edge where SCK toggles.
module spi_flash_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic sck_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [W-1:0] cnt_q;
  logic sck_q;
  logic tog;
  assign tog = en_i && cnt_q == W'(CLK_DIV - 1);
  assign rise_o = tog && !sck_q;
  assign fall_o = tog && sck_q;
  assign sck_o = sck_q;
  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= tog ? '0 : cnt_q + 1'b1;
      sck_q <= sck_q ^ tog;
    end
  end
endmodule

// File: rtl/spi_flash_ctrl.sv
// spi_flash_ctrl: Fast Read SPI NOR controller, one 24-bit address in, one little-endian word out.
// SPI_FLASH_QUAD_EN (see spi_flash_pkg) switches to quad output data phase.
module spi_flash_ctrl
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int DUMMY_CYCLES = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req_valid,
  input  logic [23:0] req_addr,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        flash_csb_o,
  output logic        flash_clk_o,
  output logic [3:0]  flash_io_o,
  output logic [3:0]  flash_io_oe,
  input  logic [3:0]  flash_io_i
);
  state_e st_q, st_d;
  logic [15:0] cnt_q, len;
  logic [31:0] sh_q, shin_q, rsp_data_q;
  logic [3:0] oe_q;
  logic req_ready_q, rsp_valid_q, csb_q, io0_q;
  logic rise, fall, last;

  spi_flash_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
    .clk_i (wb_clk_i),
    .rst_i (wb_rst_i),
    .en_i  (!csb_q),
    .sck_o (flash_clk_o),
    .rise_o(rise),
    .fall_o(fall)
  );

  // Phase length in SCK cycles; DESEL counts clk cycles instead.
  always_comb begin
    len = st_q == CMD   ? 16'(CMD_BITS) :
          st_q == ADDR  ? 16'(ADDR_BITS) :
          st_q == DUMMY ? 16'(DUMMY_CYCLES) :
          st_q == DATA  ? 16'(DATA_CYCLES) : 16'(2 * CLK_DIV);
    st_d = st_q == CMD ? ADDR : st_q == ADDR ? DUMMY : st_q == DUMMY ? DATA : DESEL;
  end
  assign last = cnt_q == len - 16'd1;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      st_q        <= IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      shin_q      <= '0;
      rsp_data_q  <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      csb_q       <= 1'b1;
      io0_q       <= 1'b0;
      oe_q        <= OE_SINGLE;
    end else begin
      rsp_valid_q <= 1'b0;
      case (st_q)
        IDLE: if (req_valid && req_ready_q) begin
          st_q        <= CMD;
          req_ready_q <= 1'b0;
          cnt_q       <= '0;
          sh_q        <= {CMD_OP, req_addr & 24'hFFFFFC};
        end
        DESEL: if (last) begin
          st_q        <= IDLE;
          req_ready_q <= 1'b1;
          cnt_q       <= '0;
        end else cnt_q <= cnt_q + 16'd1;
        default: begin
          // First cycle after accept: drop csb and present the opcode MSB before the first rise.
          if (csb_q) begin
            csb_q <= 1'b0;
            io0_q <= sh_q[31];
          end
          if (rise && st_q == DATA) shin_q <= shift_in(shin_q, flash_io_i);
          if (fall) begin
            io0_q <= sh_q[30];
            sh_q  <= sh_q << 1;
            cnt_q <= last ? '0 : cnt_q + 16'd1;
            if (last) begin
              st_q <= st_d;
              if (st_q == ADDR) oe_q <= OE_DATA;
              if (st_q == DATA) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= bswap(shin_q);
                csb_q       <= 1'b1;
                oe_q        <= OE_SINGLE;
              end
            end
          end
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign flash_csb_o = csb_q;
  assign flash_io_o  = {3'b110, io0_q};
  assign flash_io_oe = oe_q;
endmodule

// File: tb/tb_spi_flash_ctrl.sv
// tb_spi_flash_ctrl: scoreboard bench with a behavioural SPI flash per DUT (CLK_DIV=2 and CLK_DIV=1).
module tb_spi_flash_ctrl;
`ifdef SPI_FLASH_QUAD_EN
  localparam logic [7:0] CMD = 8'h6B;
  localparam int DCYC = 8;
  localparam bit QUAD = 1'b1;
`else
  localparam logic [7:0] CMD = 8'h0B;
  localparam int DCYC = 32;
  localparam bit QUAD = 1'b0;
`endif
  localparam int DUMMY = 8;
  localparam int T = 32 + DUMMY + DCYC;

  typedef struct {
    logic [31:0] data;
    logic [31:0] cmdaddr;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        req_valid [2];
  logic [23:0] req_addr [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_data [2];
  logic        csb [2];
  logic        sck [2];
  logic [3:0]  io_o [2];
  logic [3:0]  io_oe [2];
  logic [3:0]  io_i [2];

  spi_flash_ctrl #(.CLK_DIV(2), .DUMMY_CYCLES(DUMMY)) u_dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst[0]), .req_valid(req_valid[0]), .req_addr(req_addr[0]),
    .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]),
    .flash_csb_o(csb[0]), .flash_clk_o(sck[0]), .flash_io_o(io_o[0]), .flash_io_oe(io_oe[0]),
    .flash_io_i(io_i[0])
  );

  spi_flash_ctrl #(.CLK_DIV(1), .DUMMY_CYCLES(DUMMY)) u_dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst[1]), .req_valid(req_valid[1]), .req_addr(req_addr[1]),
    .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]),
    .flash_csb_o(csb[1]), .flash_clk_o(sck[1]), .flash_io_o(io_o[1]), .flash_io_oe(io_oe[1]),
    .flash_io_i(io_i[1])
  );

  exp_t q0[$];
  exp_t q1[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rises [2];
  int acc [2];
  int last_rsp [2];
  bit has_rsp [2];
  bit rst_prev [2];
  bit csb_prev [2];
  bit sck_prev [2];
  logic [31:0] cap [2];
  logic [7:0] mem [0:511];

  function automatic int cd(input int u);
    return u == 0 ? 2 : 1;
  endfunction

  task automatic chk(input int u, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL u%0d %s: got %h, expected %h", u, nm, act, exp);
    end
  endtask

  // Flash drives the bits of SCK cycle c+1 right after the fall ending cycle c.
  function automatic logic [3:0] fdata(input logic [23:0] base, input int c);
    int j;
    logic [7:0] b;
    j = c - 32 - DUMMY;
    if (j < 0 || j >= DCYC) return 4'h0;
    b = mem[9'(base[8:0] + 9'(QUAD ? j / 2 : j / 8))];
    return QUAD ? (j % 2 == 0 ? b[7:4] : b[3:0]) : {2'b00, b[7 - j % 8], 1'b0};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor + flash model, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    for (int u = 0; u < 2; u++) begin
      if (rst_prev[u]) begin
        chk(u, "rst_req_ready", 32'(req_ready[u]), 32'd1);
        chk(u, "rst_rsp_valid", 32'(rsp_valid[u]), 32'd0);
        chk(u, "rst_rsp_data", rsp_data[u], 32'd0);
        chk(u, "rst_csb", 32'(csb[u]), 32'd1);
        chk(u, "rst_sck", 32'(sck[u]), 32'd0);
        chk(u, "rst_io_o", 32'(io_o[u]), 32'hC);
        chk(u, "rst_io_oe", 32'(io_oe[u]), 32'hD);
      end
      rst_prev[u] = rst[u];
      if (rsp_valid[u]) begin
        chk(u, "rsp_expected", 32'((u == 0 ? q0.size() : q1.size()) != 0), 32'd1);
        if ((u == 0 ? q0.size() : q1.size()) != 0) begin
          if (u == 0) e = q0.pop_front();
          else e = q1.pop_front();
          chk(u, "rdata", rsp_data[u], e.data);
          chk(u, "cmd_addr", cap[u], e.cmdaddr);
          chk(u, "latency", 32'(cyc - acc[u]), 32'(1 + 2 * cd(u) * T));
        end
        last_rsp[u] = cyc;
        has_rsp[u] = 1'b1;
      end
      if (csb[u]) begin
        chk(u, "sck_idle_low", 32'(sck[u]), 32'd0);
        rises[u] = 0;
        cap[u] = '0;
      end else begin
        chk(u, "ready_busy", 32'(req_ready[u]), 32'd0);
        if (csb_prev[u] && has_rsp[u])
          chk(u, "b2b_gap", 32'((cyc - last_rsp[u]) >= 2 * cd(u)), 32'd1);
        if (sck[u] && !sck_prev[u]) begin
          rises[u]++;
          if (rises[u] <= 32) cap[u] = {cap[u][30:0], io_o[u][0]};
        end
        if (!sck[u] && sck_prev[u]) io_i[u] = fdata(cap[u][23:0], rises[u]);
        chk(u, "io_oe", 32'(io_oe[u]),
            (QUAD && (rises[u] > 32 || (rises[u] == 32 && !sck[u]))) ? 32'h0 : 32'hD);
      end
      if (req_valid[u] && req_ready[u] && !rst[u]) acc[u] = cyc + 1;
      csb_prev[u] = csb[u];
      sck_prev[u] = sck[u];
    end
  end

  task automatic read(input int u, input logic [23:0] a, input logic [31:0] d, input bit hold);
    exp_t e;
    int n;
    logic r;
    e.data = d;
    e.cmdaddr = {CMD, a & 24'hFFFFFC};
    if (u == 0) q0.push_back(e);
    else q1.push_back(e);
    req_addr[u] = a;
    req_valid[u] = 1'b1;
    n = 0;
    r = 1'b0;
    while (!r && n < 2000) begin
      @(negedge clk);
      r = req_ready[u];
      @(posedge clk);
      #1;
      n++;
    end
    if (!r) begin
      checks++;
      errors++;
      $display("FAIL u%0d accept_timeout: got no req_ready, expected one within 2000 cycles", u);
    end
    if (!hold) req_valid[u] = 1'b0;
  endtask

  task automatic wait_idle(input int u);
    int n;
    n = 0;
    while ((u == 0 ? q0.size() : q1.size()) != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if ((u == 0 ? q0.size() : q1.size()) != 0) begin
      checks++;
      errors++;
      $display("FAIL u%0d rsp_timeout: got no rsp_valid, expected one within 2000 cycles", u);
      if (u == 0) q0.delete();
      else q1.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish within 50000 cycles");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 512; i++) mem[i] = 8'hEE;
    mem[9'h010] = 8'h01; mem[9'h011] = 8'h02; mem[9'h012] = 8'h03; mem[9'h013] = 8'h04;
    mem[9'h020] = 8'hDE; mem[9'h021] = 8'hAD; mem[9'h022] = 8'hBE; mem[9'h023] = 8'hEF;
    mem[9'h100] = 8'h11; mem[9'h101] = 8'h22; mem[9'h102] = 8'h33; mem[9'h103] = 8'h44;
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1;
      req_valid[u] = 1'b0;
      req_addr[u] = '0;
      io_i[u] = 4'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    read(0, 24'h000010, 32'h04030201, 1'b0);
    wait_idle(0);
    read(0, 24'h000013, 32'h04030201, 1'b0);
    wait_idle(0);
    read(0, 24'h000020, 32'hEFBEADDE, 1'b1);
    read(0, 24'h000100, 32'h44332211, 1'b0);
    wait_idle(0);
    read(0, 24'h000010, 32'h04030201, 1'b0);
    n = 0;
    while (rises[0] < 30 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    rst[0] = 1'b1;
    q0.delete();
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    read(0, 24'h000100, 32'h44332211, 1'b0);
    wait_idle(0);
    read(1, 24'h000010, 32'h04030201, 1'b0);
    wait_idle(1);
    read(1, 24'h000100, 32'h44332211, 1'b0);
    wait_idle(1);
    repeat (10) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
